// File: rtl/mem_bus_interface.sv
// -----------------------------------------------------------------------------
// mem_bus_interface
//
// Memory-side responder for the controller's memory requests. One request is
// latched in IDLE and played out on an 8-bit multiplexed external bus:
// address low byte, optional address high byte, then a data phase that waits
// on i_ext_ready with a bounded timeout. Completion is a one-cycle
// o_mem_ready pulse, and a timeout is a one-cycle o_mem_error pulse.
//
// The last high address byte is cached. Accesses that stay in the same page
// skip the high-byte phase.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_mem_write_req  write request (held by CPU until ready/error)
//   i_mem_read_req   read request  (held by CPU until ready/error)
//   i_addr           byte address, 2*DATA_WIDTH bits
//   i_wdata          write data
//   o_rdata          read data, held until the next capture
//   o_mem_ready      one-cycle pulse: access completed
//   o_mem_error      one-cycle pulse: access aborted by timeout
//   o_busy           high while an access is in flight (state != IDLE)
//   o_ext_data_out   bus drive value
//   o_ext_data_oe    1 = o_ext_data_out drives the bus
//   i_ext_data_in    bus sample value
//   o_ext_ale        address latch enable (address phases only)
//   o_ext_addr_hi    0 = low address byte, 1 = high address byte
//   o_ext_we         write strobe (data phase only)
//   o_ext_re         read strobe  (data phase only)
//   i_ext_ready      memory ready, sampled in the data phase
// -----------------------------------------------------------------------------
module mem_bus_interface #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned TIMEOUT_WIDTH  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_mem_write_req,
    input  logic                      i_mem_read_req,
    input  logic [2*DATA_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_mem_ready,
    output logic                      o_mem_error,
    output logic                      o_busy,
    output logic [DATA_WIDTH-1:0]     o_ext_data_out,
    output logic                      o_ext_data_oe,
    input  logic [DATA_WIDTH-1:0]     i_ext_data_in,
    output logic                      o_ext_ale,
    output logic                      o_ext_addr_hi,
    output logic                      o_ext_we,
    output logic                      o_ext_re,
    input  logic                      i_ext_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StAddrLo,
        StAddrHi,
        StXfer,
        StDone,
        StErr
    } state_e;

    // Last data-phase cycle index; reaching it without i_ext_ready aborts.
    localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                    r_state;
    state_e                    w_state_next;

    logic [2*DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_is_write;
    logic [DATA_WIDTH-1:0]     r_hi_cache;
    logic                      r_hi_valid;
    logic [TIMEOUT_WIDTH-1:0]  r_timeout;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic                      w_req;
    logic                      w_page_hit;
    logic                      w_timeout_hit;

    assign w_req         = i_mem_write_req | i_mem_read_req;
    assign w_page_hit    = r_hi_valid && (r_hi_cache == r_addr[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign w_timeout_hit = (r_timeout == TimeoutLast);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_state_next = StAddrLo;
                end
            end
            StAddrLo: begin
                w_state_next = w_page_hit ? StXfer : StAddrHi;
            end
            StAddrHi: begin
                w_state_next = StXfer;
            end
            StXfer: begin
                if (i_ext_ready) begin
                    w_state_next = StDone;
                end else if (w_timeout_hit) begin
                    w_state_next = StErr;
                end
            end
            StDone:  w_state_next = StIdle;
            StErr:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_hi_cache <= '0;
            r_hi_valid <= 1'b0;
            r_timeout  <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_next;

            // The counter only runs in the data phase, so it is zero on entry.
            if (r_state != StXfer) begin
                r_timeout <= '0;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_addr     <= i_addr;
                        r_wdata    <= i_wdata;
                        // Write wins when both requests are present.
                        r_is_write <= i_mem_write_req;
                    end
                end
                StAddrHi: begin
                    r_hi_cache <= r_addr[2*DATA_WIDTH-1:DATA_WIDTH];
                    r_hi_valid <= 1'b1;
                end
                StXfer: begin
                    if (i_ext_ready) begin
                        if (!r_is_write) begin
                            r_rdata <= i_ext_data_in;
                        end
                    end else if (w_timeout_hit) begin
                        // Aborted: the memory may not have latched the page.
                        r_hi_valid <= 1'b0;
                        if (!r_is_write) begin
                            r_rdata <= '1;
                        end
                    end else begin
                        r_timeout <= r_timeout + TIMEOUT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from the state register and latched access fields only
    // -------------------------------------------------------------------------
    always_comb begin
        o_ext_data_out = '0;
        o_ext_data_oe  = 1'b0;
        o_ext_ale      = 1'b0;
        o_ext_addr_hi  = 1'b0;
        o_ext_we       = 1'b0;
        o_ext_re       = 1'b0;
        o_mem_ready    = 1'b0;
        o_mem_error    = 1'b0;
        unique case (r_state)
            StAddrLo: begin
                o_ext_ale      = 1'b1;
                o_ext_data_oe  = 1'b1;
                o_ext_data_out = r_addr[DATA_WIDTH-1:0];
            end
            StAddrHi: begin
                o_ext_ale      = 1'b1;
                o_ext_addr_hi  = 1'b1;
                o_ext_data_oe  = 1'b1;
                o_ext_data_out = r_addr[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            StXfer: begin
                o_ext_we      = r_is_write;
                o_ext_re      = !r_is_write;
                o_ext_data_oe = r_is_write;
                if (r_is_write) begin
                    o_ext_data_out = r_wdata;
                end
            end
            StDone:  o_mem_ready = 1'b1;
            StErr:   o_mem_error = 1'b1;
            default: begin
            end
        endcase
    end

    assign o_busy  = (r_state != StIdle);
    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_mem_bus_interface.sv
module tb_mem_bus_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write_req;
    logic        mem_read_req;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        mem_ready;
    logic        mem_error;
    logic        busy;
    logic [7:0]  ext_data_out;
    logic        ext_data_oe;
    logic [7:0]  ext_data_in;
    logic        ext_ale;
    logic        ext_addr_hi;
    logic        ext_we;
    logic        ext_re;
    logic        ext_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Observations of one access, filled by run_access.
    int          lat;
    int          n_x;
    int          n_hi;
    int          n_rdy;
    int          n_err;
    logic [7:0]  lo_b;
    logic [7:0]  hi_b;
    logic        x_we;
    logic        x_re;
    logic        x_oe;
    logic [7:0]  x_out;
    logic [7:0]  rd_at;
    logic        bus_rel;
    logic        busy_after;
    logic        done;

    always #5 clk = ~clk;

    mem_bus_interface #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (15),
        .TIMEOUT_WIDTH  (4)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_mem_write_req (mem_write_req),
        .i_mem_read_req  (mem_read_req),
        .i_addr          (addr),
        .i_wdata         (wdata),
        .o_rdata         (rdata),
        .o_mem_ready     (mem_ready),
        .o_mem_error     (mem_error),
        .o_busy          (busy),
        .o_ext_data_out  (ext_data_out),
        .o_ext_data_oe   (ext_data_oe),
        .i_ext_data_in   (ext_data_in),
        .o_ext_ale       (ext_ale),
        .o_ext_addr_hi   (ext_addr_hi),
        .o_ext_we        (ext_we),
        .o_ext_re        (ext_re),
        .i_ext_ready     (ext_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch the bus until two cycles past the end pulse.
    // ready_after: 0 = ready from the start, N>0 = low for N data cycles, -1 = never.
    task automatic run_access(input logic wr, input logic rd, input logic [15:0] a,
                              input logic [7:0] wd, input logic [7:0] din,
                              input int ready_after);
        mem_write_req = wr;
        mem_read_req  = rd;
        addr          = a;
        wdata         = wd;
        ext_data_in   = din;
        ext_ready     = (ready_after == 0);
        lat = 0; n_x = 0; n_hi = 0; n_rdy = 0; n_err = 0;
        lo_b = 8'h00; hi_b = 8'h00; x_we = 1'b0; x_re = 1'b0; x_oe = 1'b0;
        x_out = 8'h00; rd_at = 8'h00; bus_rel = 1'b0; busy_after = 1'b1; done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ext_ale && !ext_addr_hi) lo_b = ext_data_out;
            if (ext_ale && ext_addr_hi) begin
                n_hi++;
                hi_b = ext_data_out;
            end
            if (ext_re || ext_we) begin
                n_x++;
                x_we  = ext_we;
                x_re  = ext_re;
                x_oe  = ext_data_oe;
                x_out = ext_data_out;
                if (ready_after > 0 && n_x == ready_after + 1) ext_ready = 1'b1;
            end
            if (done && c == lat) busy_after = busy;
            if (mem_ready || mem_error) begin
                if (!done) begin
                    lat     = c + 1;
                    rd_at   = rdata;
                    bus_rel = ext_data_oe | ext_ale;
                end
                done = 1'b1;
                if (mem_ready) n_rdy++;
                if (mem_error) n_err++;
                mem_write_req = 1'b0;
                mem_read_req  = 1'b0;
            end
            if (done && c >= lat + 1) break;
        end
        chk("access_completes", {31'd0, done}, 32'd1);
        mem_write_req = 1'b0;
        mem_read_req  = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        mem_write_req = 1'b0;
        mem_read_req  = 1'b0;
        addr          = 16'h0000;
        wdata         = 8'h00;
        ext_data_in   = 8'h00;
        ext_ready     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ext", {19'd0, ext_ale, ext_addr_hi, ext_we, ext_re, ext_data_oe, ext_data_out},
            32'd0);
        chk("rst_flags", {29'd0, mem_ready, mem_error, busy}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        reset = 1'b0;
        tick();

        // Write 1234 <- AB, page miss, memReady at cycle 4
        run_access(1'b1, 1'b0, 16'h1234, 8'hAB, 8'h00, 0);
        chk("w1_lat", lat, 4);
        chk("w1_lo", {24'd0, lo_b}, 32'h34);
        chk("w1_hi", {24'd0, hi_b}, 32'h12);
        chk("w1_nhi", n_hi, 1);
        chk("w1_strobes", {29'd0, x_we, x_re, x_oe}, 32'b101);
        chk("w1_wdata", {24'd0, x_out}, 32'hAB);
        chk("w1_nrdy", n_rdy, 1);
        chk("w1_busrel", {31'd0, bus_rel}, 32'd0);
        chk("w1_busy_after", {31'd0, busy_after}, 32'd0);
        chk("w1_rdata_kept", {24'd0, rdata}, 32'h00);

        // Read 1240, same page: no high-byte phase, memReady at cycle 3
        run_access(1'b0, 1'b1, 16'h1240, 8'h00, 8'h5C, 0);
        chk("r1_lat", lat, 3);
        chk("r1_nhi", n_hi, 0);
        chk("r1_lo", {24'd0, lo_b}, 32'h40);
        chk("r1_strobes", {29'd0, x_we, x_re, x_oe}, 32'b010);
        chk("r1_rdata", {24'd0, rd_at}, 32'h5C);
        chk("r1_rdata_held", {24'd0, rdata}, 32'h5C);

        // Read with three wait-states: strobe held 4 cycles, 3 cycles later
        run_access(1'b0, 1'b1, 16'h1250, 8'h00, 8'hC3, 3);
        chk("r2_nx", n_x, 4);
        chk("r2_lat", lat, 6);
        chk("r2_rdata", {24'd0, rd_at}, 32'hC3);

        // Read that never sees ready: error after 15 data cycles
        run_access(1'b0, 1'b1, 16'h1260, 8'h00, 8'h11, -1);
        chk("to_nx", n_x, 15);
        chk("to_lat", lat, 17);
        chk("to_nerr", n_err, 1);
        chk("to_nrdy", n_rdy, 0);
        chk("to_rdata", {24'd0, rd_at}, 32'hFF);
        chk("to_busrel", {31'd0, bus_rel}, 32'd0);

        // Same page after the abort: cache was dropped, high byte re-emitted
        run_access(1'b0, 1'b1, 16'h1270, 8'h00, 8'h77, 0);
        chk("pg_nhi", n_hi, 1);
        chk("pg_hi", {24'd0, hi_b}, 32'h12);
        chk("pg_lat", lat, 4);
        chk("pg_rdata", {24'd0, rd_at}, 32'h77);

        // Both requests: write wins, exactly one memReady, rdata untouched
        run_access(1'b1, 1'b1, 16'h1280, 8'h5A, 8'h99, 0);
        chk("both_strobes", {29'd0, x_we, x_re, x_oe}, 32'b101);
        chk("both_wdata", {24'd0, x_out}, 32'h5A);
        chk("both_nrdy", n_rdy, 1);
        chk("both_lat", lat, 3);
        chk("both_rdata", {24'd0, rdata}, 32'h77);

        // Reset in the data phase of a page-miss read
        mem_read_req = 1'b1;
        addr         = 16'h3456;
        ext_ready    = 1'b0;
        tick();
        tick();
        tick();
        chk("rx_in_xfer", {31'd0, ext_re}, 32'd1);
        reset        = 1'b1;
        mem_read_req = 1'b0;
        tick();
        chk("rx_ext", {19'd0, ext_ale, ext_addr_hi, ext_we, ext_re, ext_data_oe, ext_data_out},
            32'd0);
        chk("rx_flags", {29'd0, mem_ready, mem_error, busy}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rx_no_pulse", {30'd0, mem_ready, mem_error}, 32'd0);

        // Page 34 was cached by the abandoned access; reset must have dropped it
        run_access(1'b0, 1'b1, 16'h3456, 8'h00, 8'h42, 0);
        chk("rx_nhi", n_hi, 1);
        chk("rx_hi", {24'd0, hi_b}, 32'h34);
        chk("rx_lat", lat, 4);
        chk("rx_rdata", {24'd0, rd_at}, 32'h42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
